// File: rtl/ofm_ctrl_pkg.sv
// ofm_ctrl_pkg: shared FSM encoding and OFM constants for the output-feature-map write path
package ofm_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int OFM_DEPTH = 512;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible requester at or after rr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PW-1:0]      rr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);
  logic [NUM_REQ-1:0] hi;
  // lowest set bit at or above rr, else wrap to lowest set bit overall
  always_comb begin
    hi = elig & ({NUM_REQ{1'b1}} << rr);
    grant = (|hi) ? (hi & (~hi + NUM_REQ'(1))) : (elig & (~elig + NUM_REQ'(1)));
    valid = |elig;
  end
endmodule

// File: rtl/ofm_write_arbiter.sv
// ofm_write_arbiter: round-robin sharing of the OFM write port between filter engines,
// each streaming OUT_LEN words into its own region; done marks all regions written
module ofm_write_arbiter
  import ofm_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OUT_LEN = 128,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [ADR_W-1:0]          ofm_adr,
  output logic [DATA_W-1:0]         ofm_in,
  output logic                      ofm_we,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(OUT_LEN + 1);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ * OUT_LEN > OFM_DEPTH) begin : g_depth_check
    $error("ofm_write_arbiter: NUM_REQ*OUT_LEN exceeds OFM depth");
  end

  state_t state, state_n;
  logic [CW-1:0] cnt [NUM_REQ];
  logic [PW-1:0] rr, w;
  logic [NUM_REQ-1:0] elig, full, grant;
  logic valid, restart;
  logic [CW-1:0] w_cnt;
  logic [DATA_W-1:0] w_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .elig(elig),
    .rr(rr),
    .grant(grant),
    .valid(valid)
  );

  // a requester acked this cycle is masked so a not-yet-dropped request is not granted twice
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      full[i] = cnt[i] == CW'(OUT_LEN);
      elig[i] = (state == RUN) && req[i] && !full[i] && !ack[i];
    end
  end

  always_comb begin
    w = '0;
    w_cnt = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        w = PW'(i);
        w_cnt = cnt[i];
        w_data = data[i*DATA_W +: DATA_W];
      end
  end

  assign restart = start && (state != RUN);

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // once every counter is full no grant can be pending, so DONE follows the last write by one cycle
  always_comb
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN)  ? (&full ? DONE : RUN) :
                                (start ? RUN : DONE);

  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      ack <= '0;
      ofm_we <= 1'b0;
      ofm_adr <= '0;
      ofm_in <= '0;
      rr <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      ack <= grant;
      ofm_we <= valid;
      if (valid) begin
        rr <= (w == PW'(NUM_REQ - 1)) ? '0 : w + PW'(1);
        ofm_adr <= ADR_W'(w) * ADR_W'(OUT_LEN) + ADR_W'(w_cnt);
        ofm_in <= w_data;
      end
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= restart ? '0 : cnt[i] + CW'(grant[i]);
    end
endmodule

// File: tb/tb_ofm_write_arbiter.sv
// tb_ofm_write_arbiter: directed + randomized checks of ofm_write_arbiter against a word-count reference model
module tb_ofm_write_arbiter;
  localparam int N = 4, L = 128, DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0;
  logic [N-1:0] req = '0;
  logic [DW-1:0] dw [N];
  logic [N*DW-1:0] data;
  logic [N-1:0] ack;
  logic [31:0] ofm_adr;
  logic [DW-1:0] ofm_in;
  logic ofm_we, busy, done;

  logic s_rst_n = 1'b0, s_start = 1'b0;
  logic [1:0] s_req = '0;
  logic [DW-1:0] s_dw [2];
  logic [2*DW-1:0] s_data;
  logic [1:0] s_ack;
  logic [31:0] s_adr;
  logic [DW-1:0] s_in;
  logic s_we, s_busy, s_done;

  assign data = {dw[3], dw[2], dw[1], dw[0]};
  assign s_data = {s_dw[1], s_dw[0]};

  always #5 clk = ~clk;

  ofm_write_arbiter #(.NUM_REQ(N), .OUT_LEN(L), .DATA_W(DW), .ADR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req), .data(data), .ack(ack),
    .ofm_adr(ofm_adr), .ofm_in(ofm_in), .ofm_we(ofm_we), .busy(busy), .done(done)
  );

  ofm_write_arbiter #(.NUM_REQ(2), .OUT_LEN(3), .DATA_W(DW), .ADR_W(32)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .req(s_req), .data(s_data), .ack(s_ack),
    .ofm_adr(s_adr), .ofm_in(s_in), .ofm_we(s_we), .busy(s_busy), .done(s_done)
  );

  int errors = 0, checks = 0;
  // reference model: phase 0 idle / 1 run / 2 done, words written per region, next search start
  int m_phase, m_rr, m_ack, m_we;
  int m_cnt [N];
  logic [31:0] m_adr, m_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    int w, tot, np;
    w = -1;
    tot = 0;
    if (!rst_n) begin
      m_phase = 0; m_rr = 0; m_ack = -1; m_we = 0; m_adr = 0; m_in = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    if (m_phase == 1)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (w < 0 && req[i] && m_cnt[i] < L && m_ack != i) w = i;
      end
    for (int i = 0; i < N; i++) tot += m_cnt[i];
    np = (m_phase == 0) ? (start ? 1 : 0) : (m_phase == 1) ? ((tot == N * L) ? 2 : 1) : (start ? 1 : 2);
    if (start && m_phase != 1)
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    if (w >= 0) begin
      m_ack = w; m_we = 1; m_adr = w * L + m_cnt[w]; m_in = dw[w];
      m_cnt[w]++;
      m_rr = (w + 1) % N;
    end else begin
      m_ack = -1; m_we = 0;
    end
    m_phase = np;
  endfunction

  task automatic check_all();
    chk("ack", ack, (m_ack < 0) ? 0 : (1 << m_ack));
    chk("we", ofm_we, m_we);
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("adr", ofm_adr, m_adr);
    chk("in", ofm_in, m_in);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  int nw, k, last, fd, sw;
  int q [N];
  logic [31:0] adrs [5];
  logic [31:0] sadr [8];
  logic [31:0] sdat [8];

  initial begin
    for (int i = 0; i < N; i++) dw[i] = '0;
    for (int i = 0; i < 2; i++) s_dw[i] = '0;
    @(negedge clk);
    // reset with every request raised
    rst_n = 0; s_rst_n = 0; req = '1;
    repeat (2) tick();
    rst_n = 1; s_rst_n = 1;
    repeat (3) tick();
    chk("t1_no_ack_idle", ack, 0);
    // single requester, with a start pulse mid-run that must be ignored
    req = '0; start = 1; tick(); start = 0;
    req = 4'b0010; k = 0; dw[1] = 32'h100; nw = 0; last = 0;
    for (int c = 0; c < 300; c++) begin
      start = (c == 50);
      tick();
      if (ofm_we) begin nw++; last = ofm_adr; end
      if (ack[1]) begin k++; dw[1] = 32'h100 + k; end
    end
    start = 0;
    chk("t2_writes", nw, 128);
    chk("t2_last_adr", last, 255);
    chk("t2_no_done", done, 0);
    // full contention
    rst_n = 0; req = '0; tick(); rst_n = 1;
    start = 1; tick(); start = 0;
    req = '1;
    for (int i = 0; i < N; i++) begin q[i] = 0; dw[i] = i << 12; end
    nw = 0; last = -1; fd = -1;
    for (int c = 0; c < 600 && fd < 0; c++) begin
      tick();
      if (ofm_we) begin
        if (nw < 5) adrs[nw] = ofm_adr;
        nw++; last = c;
      end
      if (done && fd < 0) begin fd = c; chk("t3_busy_fall", busy, 0); end
      for (int i = 0; i < N; i++) if (ack[i]) begin q[i]++; dw[i] = (i << 12) + q[i]; end
    end
    chk("t3_writes", nw, 512);
    chk("t3_we_every_cycle", last, 511);
    chk("t3_done_latency", fd, last + 1);
    chk("t3_adr0", adrs[0], 0);
    chk("t3_adr1", adrs[1], 128);
    chk("t3_adr2", adrs[2], 256);
    chk("t3_adr3", adrs[3], 384);
    chk("t3_adr4", adrs[4], 1);
    // start from DONE restarts at address 0
    start = 1; tick(); start = 0;
    chk("t5_done_fall", done, 0);
    tick();
    chk("t5_restart_we", ofm_we, 1);
    chk("t5_restart_adr", ofm_adr, 0);
    nw = 1;
    for (int c = 0; c < 40 && nw < 10; c++) begin
      for (int i = 0; i < N; i++) if (ack[i]) dw[i] = $urandom;
      tick();
      if (ofm_we) nw++;
    end
    chk("t6_ten_writes", nw, 10);
    // reset mid-run with requests held; rr must return to 0
    rst_n = 0; tick();
    chk("t6_reset_ack", ack, 0);
    chk("t6_reset_busy", busy, 0);
    rst_n = 1; tick();
    start = 1; tick(); start = 0;
    tick();
    chk("t6_restart_ack", ack, 1);
    chk("t6_restart_adr", ofm_adr, 0);
    // two requesters of three words, only requester 0 active first
    req = '0;
    s_rst_n = 0; tick(); s_rst_n = 1;
    s_start = 1; tick(); s_start = 0;
    s_req = 2'b01; k = 0; s_dw[0] = 32'hA0; sw = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_we) begin if (sw < 8) begin sadr[sw] = s_adr; sdat[sw] = s_in; end sw++; end
      if (s_ack[0]) begin k++; s_dw[0] = 32'hA0 + k; end
    end
    chk("t4_writes_r0", sw, 3);
    chk("t4_no_done", s_done, 0);
    chk("t4_busy", s_busy, 1);
    s_req = 2'b10; k = 0; s_dw[1] = 32'hB0;
    for (int c = 0; c < 20 && !s_done; c++) begin
      tick();
      if (s_we) begin if (sw < 8) begin sadr[sw] = s_adr; sdat[sw] = s_in; end sw++; end
      if (s_ack[1]) begin k++; s_dw[1] = 32'hB0 + k; end
    end
    chk("t4_writes_total", sw, 6);
    chk("t4_done", s_done, 1);
    for (int i = 0; i < 6; i++) chk("t4_adr", sadr[i], i);
    chk("t4_data2", sdat[2], 32'hA2);
    chk("t4_data5", sdat[5], 32'hB2);
    // randomized traffic with occasional stray start pulses
    rst_n = 0; req = '0; tick(); rst_n = 1;
    start = 1; tick(); start = 0;
    for (int c = 0; c < 6000 && !done; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] || ack[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          dw[i] = $urandom;
        end
      start = ($urandom_range(0, 63) == 0);
      tick();
    end
    start = 0;
    chk("rand_done", done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ofm_write_arbiter.md
Name: ofm_write_arbiter

Overview:
- Shares the single write port of the output-feature-map memory (adr/in/we, 512 words) between NUM_REQ filter engines.
- Each engine streams OUT_LEN results into its own region of the memory. The arbiter grants round-robin and generates addresses.
- It raises `done` once every region is fully written, which releases the memory's file dump.
- Sits between the per-filter compute units and the OFM instance in the layer top.

Parameters:
- NUM_REQ, 4, number of requesting filter engines.
- OUT_LEN, 128, words each requester writes per run. NUM_REQ*OUT_LEN must be ≤ 512.
- DATA_W, 32, data word width.
- ADR_W, 32, OFM address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- req  in  NUM_REQ  per-requester write request. Held with data until acked.
- data  in  NUM_REQ*DATA_W  flattened write data. Requester i owns bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle grant acknowledge, one-hot or zero.
- ofm_adr  out  ADR_W  OFM write address.
- ofm_in  out  DATA_W  OFM write data.
- ofm_we  out  1  OFM write enable.
- busy  out  1  high in RUN.
- done  out  1  level; high in DONE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE.
  - Outputs go to zero: ack=0, ofm_we=0, ofm_adr=0, ofm_in=0, busy=0, done=0.
  - All counters cnt[i]=0 and the round-robin pointer rr=0.
  - Reset mid-run abandons the run. Writes already issued stay in memory; no further acks are given.
- FSM states and transitions:
  - IDLE: on start, go to RUN and clear all cnt[i].
  - RUN: go to DONE on the edge after the final write is issued, i.e. all cnt[i]==OUT_LEN and ofm_we=0. `start` is ignored in RUN.
  - DONE: done=1, held indefinitely. On start, clear counters, go to RUN, done falls.
- Eligibility in RUN: requester i is eligible when all of the following hold:
  - req[i]=1;
  - cnt[i]<OUT_LEN;
  - ack[i]=0 in the current cycle. This prevents double-granting a request that has not yet dropped.
- Arbitration:
  - Among eligible requesters, the winner w is the first at or after rr, searching with wrap-around.
  - At the edge, rr becomes (w+1) mod NUM_REQ. rr is unchanged when there is no winner.
- Grant timing: a grant decided in cycle t registers, visible in cycle t+1:
  - ack[w]=1;
  - ofm_we=1;
  - ofm_adr = w*OUT_LEN + cnt[w], zero-extended to ADR_W;
  - ofm_in = data[w];
  - cnt[w] increments.
  - With no winner, ofm_we=0 and ack=0. ofm_adr/ofm_in hold their last values.
- Requester protocol:
  - Keep req and data stable until ack is seen.
  - Either drop req or present the next word at the edge ending the ack cycle.
  - Peak throughput is one write per cycle aggregate, and one write per 2 cycles per requester.
- Requests from a requester with cnt[i]==OUT_LEN are never acked. The same applies to any req outside RUN.
- Counter width is $clog2(OUT_LEN+1). Counters saturate at OUT_LEN.
- The OFM write port samples on clk with ofm_we as issued. No extra latency is added.

Decomposition:
- Shared package ofm_ctrl_pkg holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the OFM depth constant 512;
  - DATA_W default.
- One sub-module is natural: rr_arbiter. It is parameterised on NUM_REQ; inputs are the eligible vector and rr; output is the one-hot winner plus a valid flag. It is purely combinational and reusable for the input-feature-map read side.
- Counters, address generation and the FSM stay in ofm_write_arbiter.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, with req=4'hF -> ack=0, ofm_we=0, done=0, busy=0 throughout. After release, still no ack without start.
2. Single requester: start; hold req[1]=1 continuously, data[1] = 0x100+k for word k. Expected:
   - ofm_we every other cycle;
   - ofm_adr = 128, 129, … 255;
   - ofm_in = 0x100 … 0x17F;
   - no writes after 128 acks.
3. Full contention: start; all req=1 continuously. Expected:
   - grant order 0,1,2,3,0,…;
   - ofm_adr = 0, 128, 256, 384, 1, 129, …;
   - ofm_we high every cycle;
   - 512 writes total;
   - done=1 exactly one cycle after the last ofm_we;
   - busy falls in the same cycle.
4. Override NUM_REQ=2, OUT_LEN=3; only requester 0 active. Expected:
   - after 3 acks, req[0] is ignored and no done;
   - then requester 1 writes 3 words -> adr 3, 4, 5, then done.
5. A start pulse in RUN has no effect on counters or grants. A start in DONE -> done falls next cycle and the next write goes to adr 0 again.
6. Reset mid-run: rst_n=0 after 10 writes, with req held high -> no ack, IDLE. A subsequent start restarts at adr 0 with rr=0.
